// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// VGA raster timing generator for the pixel clock domain. The display is held
// idle until the PLL lock flag has been stable for LOCK_DLY clocks. After that
// the generator produces hsync/vsync, the active-video enable, pixel
// coordinates and line/frame strobes. Every output is registered, and all
// outputs are decoded from the same (h, v) pair, so they always describe the
// same pixel.
//
// Ports:
//   clk         in   pixel clock
//   rst         in   asynchronous active-high reset
//   locked      in   PLL lock flag (asynchronous to clk)
//   hsync       out  horizontal sync, asserted level = SYNC_ACTIVE
//   vsync       out  vertical sync, asserted level = SYNC_ACTIVE
//   video_on    out  high during visible pixels
//   x           out  horizontal count 0..H_TOTAL-1 (0 when idle)
//   y           out  vertical count 0..V_TOTAL-1 (0 when idle)
//   line_start  out  one-clock strobe at x==0
//   frame_start out  one-clock strobe at x==0, y==0
//   running     out  high while the raster is running
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   LOCK_DLY    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start,
    output logic       running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Decode bounds are held at 11 bits: a sync pulse ending exactly at
    // a total of 1024 must not wrap to zero.
    localparam logic [10:0] C_H_ACT = 11'(H_ACTIVE);
    localparam logic [10:0] C_HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] C_HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] C_V_ACT = 11'(V_ACTIVE);
    localparam logic [10:0] C_VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] C_VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  C_H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  C_V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  C_SETTLE_LAST = 10'(LOCK_DLY - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    logic [1:0] r_sync;
    logic       w_lock_s;
    state_t     r_state;
    state_t     w_state_next;
    logic [9:0] r_settle;
    logic [9:0] w_settle_next;
    logic [9:0] r_h;
    logic [9:0] r_v;
    logic [9:0] w_h_next;
    logic [9:0] w_v_next;
    logic       w_run_next;
    logic [10:0] w_hx;
    logic [10:0] w_vx;
    logic       w_vo_next;
    logic       w_hs_next;
    logic       w_vs_next;

    assign w_lock_s = r_sync[1];

    // Next-state logic. The raster counters are forced to zero outside RUN
    // so that entering RUN always begins at pixel (0, 0).
    always_comb begin
        w_state_next  = r_state;
        w_settle_next = r_settle;
        w_h_next      = 10'd0;
        w_v_next      = 10'd0;
        case (r_state)
            WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_next  = SETTLE;
                    w_settle_next = 10'd0;
                end
            end
            SETTLE: begin
                if (!w_lock_s) begin
                    w_state_next = WAIT_LOCK;
                end else if (r_settle == C_SETTLE_LAST) begin
                    w_state_next = RUN;
                end else begin
                    w_settle_next = r_settle + 10'd1;
                end
            end
            RUN: begin
                if (!w_lock_s) begin
                    w_state_next = WAIT_LOCK;
                end else if (r_h == C_H_LAST) begin
                    w_h_next = 10'd0;
                    w_v_next = (r_v == C_V_LAST) ? 10'd0 : r_v + 10'd1;
                end else begin
                    w_h_next = r_h + 10'd1;
                    w_v_next = r_v;
                end
            end
            default: begin
                w_state_next = WAIT_LOCK;
            end
        endcase
    end

    // Outputs are decoded from the next (h, v) so the registered outputs
    // line up with the registered counters in the same cycle.
    assign w_run_next = (w_state_next == RUN);
    assign w_hx       = {1'b0, w_h_next};
    assign w_vx       = {1'b0, w_v_next};
    assign w_vo_next  = (w_hx < C_H_ACT) && (w_vx < C_V_ACT);
    assign w_hs_next  = (w_hx >= C_HS_BEG) && (w_hx < C_HS_END);
    assign w_vs_next  = (w_vx >= C_VS_BEG) && (w_vx < C_VS_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync      <= 2'b00;
            r_state     <= WAIT_LOCK;
            r_settle    <= 10'd0;
            r_h         <= 10'd0;
            r_v         <= 10'd0;
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            video_on    <= 1'b0;
            x           <= 10'd0;
            y           <= 10'd0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], locked};
            r_state     <= w_state_next;
            r_settle    <= w_settle_next;
            r_h         <= w_h_next;
            r_v         <= w_v_next;
            hsync       <= (w_run_next && w_hs_next) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync       <= (w_run_next && w_vs_next) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            video_on    <= w_run_next && w_vo_next;
            x           <= w_run_next ? w_h_next : 10'd0;
            y           <= w_run_next ? w_v_next : 10'd0;
            line_start  <= w_run_next && (w_h_next == 10'd0);
            frame_start <= w_run_next && (w_h_next == 10'd0) && (w_v_next == 10'd0);
            running     <= w_run_next;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Bench for vga_timing_gen using a reduced raster so whole frames fit in a
// short run: 16+4+8+4 = 32 clocks per line, 12+2+2+4 = 20 lines per frame,
// 640 clocks per frame, LOCK_DLY = 16, active-low syncs.
// A vector table gives expected outputs at chosen edge numbers counted
// from reset release with locked already high; hand sequences cover lock
// loss, lock glitches during settling and asynchronous reset mid-frame.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] x;
    logic [9:0] y;
    logic       line_start;
    logic       frame_start;
    logic       running;

    int tests = 0;
    int fails = 0;

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .SYNC_ACTIVE(1'b0), .LOCK_DLY(16)
    ) dut (
        .clk(clk), .rst(rst), .locked(locked),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .x(x), .y(y), .line_start(line_start),
        .frame_start(frame_start), .running(running)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         edge_n;
        logic [9:0] ex;
        logic [9:0] ey;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       ls;
        logic       fs;
        logic       run;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl [NVEC];

    localparam logic [25:0] IDLE = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [25:0] FSTART = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    function automatic logic [25:0] dut_vec();
        return {x, y, hsync, vsync, video_on, line_start, frame_start, running};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_vec(input string name, input logic [25:0] exp);
        logic [25:0] got;
        got = dut_vec();
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b vo=%b ls=%b fs=%b run=%b, want x=%0d y=%0d hs=%b vs=%b vo=%b ls=%b fs=%b run=%b",
                     name, got[25:16], got[15:6], got[5], got[4], got[3], got[2], got[1], got[0],
                     exp[25:16], exp[15:6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end else begin
            $display("[TB] ok %s x=%0d y=%0d", name, got[25:16], got[15:6]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end else begin
            $display("[TB] ok %s = %0d", name, got);
        end
    endtask

    // Relock restart: RUN must appear exactly on the 19th edge after locked rises.
    task automatic relock_check(input string name);
        for (int n = 1; n <= 19; n++) begin
            tick();
            if (n < 19) check_int({name, " still idle"}, int'(running), 0);
            else        check_vec({name, " frame_start"}, FSTART);
        end
    endtask

    initial begin
        int idx;
        int vo_cnt, ls_cnt, vs_cnt, hs_cnt, fs_cnt;
        bit found;

        tbl[0]  = '{2,   10'd0,  10'd0,  1, 1, 0, 0, 0, 0};
        tbl[1]  = '{18,  10'd0,  10'd0,  1, 1, 0, 0, 0, 0};
        tbl[2]  = '{19,  10'd0,  10'd0,  1, 1, 1, 1, 1, 1};
        tbl[3]  = '{34,  10'd15, 10'd0,  1, 1, 1, 0, 0, 1};
        tbl[4]  = '{35,  10'd16, 10'd0,  1, 1, 0, 0, 0, 1};
        tbl[5]  = '{39,  10'd20, 10'd0,  0, 1, 0, 0, 0, 1};
        tbl[6]  = '{46,  10'd27, 10'd0,  0, 1, 0, 0, 0, 1};
        tbl[7]  = '{47,  10'd28, 10'd0,  1, 1, 0, 0, 0, 1};
        tbl[8]  = '{50,  10'd31, 10'd0,  1, 1, 0, 0, 0, 1};
        tbl[9]  = '{51,  10'd0,  10'd1,  1, 1, 1, 1, 0, 1};
        tbl[10] = '{386, 10'd15, 10'd11, 1, 1, 1, 0, 0, 1};
        tbl[11] = '{403, 10'd0,  10'd12, 1, 1, 0, 1, 0, 1};
        tbl[12] = '{467, 10'd0,  10'd14, 1, 0, 0, 1, 0, 1};
        tbl[13] = '{487, 10'd20, 10'd14, 0, 0, 0, 0, 0, 1};
        tbl[14] = '{530, 10'd31, 10'd15, 1, 0, 0, 0, 0, 1};
        tbl[15] = '{531, 10'd0,  10'd16, 1, 1, 0, 1, 0, 1};
        tbl[16] = '{658, 10'd31, 10'd19, 1, 1, 0, 0, 0, 1};
        tbl[17] = '{659, 10'd0,  10'd0,  1, 1, 1, 1, 1, 1};

        // Reset state and idle with no lock.
        @(negedge clk);
        @(negedge clk);
        check_vec("reset state", IDLE);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            check_vec($sformatf("no lock idle %0d", i), IDLE);
        end

        // Startup with locked high before reset release, then the table.
        @(negedge clk);
        rst = 1'b1;
        locked = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idx = 0;
        vo_cnt = 0; ls_cnt = 0; vs_cnt = 0; hs_cnt = 0; fs_cnt = 0;
        for (int n = 1; n <= 700; n++) begin
            tick();
            if (n >= 19 && n <= 658) begin
                vo_cnt += int'(video_on);
                ls_cnt += int'(line_start);
                fs_cnt += int'(frame_start);
                vs_cnt += int'(!vsync);
                hs_cnt += int'(!hsync);
            end
            while (idx < NVEC && tbl[idx].edge_n == n) begin
                check_vec($sformatf("vec edge %0d", n),
                          {tbl[idx].ex, tbl[idx].ey, tbl[idx].hs, tbl[idx].vs,
                           tbl[idx].vo, tbl[idx].ls, tbl[idx].fs, tbl[idx].run});
                idx++;
            end
        end
        check_int("vectors applied", idx, NVEC);
        check_int("frame video_on count", vo_cnt, 192);
        check_int("frame line_start count", ls_cnt, 20);
        check_int("frame frame_start count", fs_cnt, 1);
        check_int("frame vsync low clocks", vs_cnt, 64);
        check_int("frame hsync low clocks", hs_cnt, 160);

        // Lock loss at x=10, y=5.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            tick();
            if (x == 10'd10 && y == 10'd5 && running) found = 1'b1;
        end
        check_int("reach x10 y5", int'(found), 1);
        locked = 1'b0;
        tick();
        check_vec("drop edge1", {10'd11, 10'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        tick();
        check_vec("drop edge2", {10'd12, 10'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        tick();
        check_vec("drop edge3 idle", IDLE);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_vec("unlocked idle", IDLE);
        end
        locked = 1'b1;
        relock_check("relock");

        // Lock glitch during settling forces a full restart.
        locked = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check_vec("glitch pre idle", IDLE);
        locked = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_int("settle running", int'(running), 0);
        end
        locked = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_int("glitch running", int'(running), 0);
        end
        locked = 1'b1;
        relock_check("after glitch");

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 50; i++) tick();
        check_int("running before rst", int'(running), 1);
        #2;
        rst = 1'b1;
        #1;
        check_vec("async rst idle", IDLE);
        @(negedge clk);
        rst = 1'b0;
        relock_check("after rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule
